mps_spi_master: RTL and testbench
=================================

// Module: mps_spi_master
// PURPOSE
// Host-side SPI initiator that configures and reads back the pixel-sensor top over SS/SCLK/MOSI/MISO.
// The data bus is byte-wide and parallel: each SCLK pulse carries a whole byte on MOSI[7:0] and MISO[7:0].
// Every transaction is one command byte (beat 0) followed by `len` data beats.
// Runs in the clk1 domain; SCLK is generated by dividing clk1.
// PARAMETERS
// CLK_DIV    4   clk1 cycles per SCLK half-period (>=1)
// SETUP_CYC  2   clk1 cycles from SS fall to first SCLK rise, and from last SCLK fall to SS rise (>=1)
// IDLE_CYC   2   minimum clk1 cycles SS stays high between transactions (>=1)
// LEN_W      4   width of len; max data beats = 2**LEN_W-1
// PORTS
// clk1         in   1      system clock; all logic on posedge
// sys_reset    in   1      synchronous, active-high reset
// start_valid  in   1      host requests a transaction
// start_ready  out  1      high only in IDLE; accept = start_valid & start_ready
// cmd          in   8      command byte, sampled at accept
// len          in   LEN_W  number of data beats after cmd, sampled at accept (0 = command only)
// wdata        in   8      next data byte for MOSI
// wdata_valid  in   1      wdata is available
// wdata_ready  out  1      1-cycle pulse: wdata consumed this cycle
// rdata        out  8      MISO byte captured at the SCLK rise of a data beat
// rdata_valid  out  1      1-cycle pulse qualifying rdata
// busy         out  1      high from the cycle after accept until return to IDLE
// SS           out  1      slave select, active low
// SCLK         out  1      serial clock, idle low
// MOSI         out  8      parallel output byte; changes only while SCLK is low
// MISO         in   8      parallel input byte from the slave
// BEHAVIOUR
// - Reset values: SS=1, SCLK=0, MOSI=0, rdata=0, rdata_valid=0, wdata_ready=0, busy=0, start_ready=1.
//   Reset is taken at the next clk1 edge, aborts any transaction, and generates no SCLK edge.
// - FSM states: IDLE, SETUP, HIGH, LOW, WAIT, HOLD, GAP.
//   All outputs are registered.
// - IDLE -> SETUP on accept. At the next edge: SS=0, MOSI=cmd, SCLK=0, busy=1.
//   Latch len into the beat counter.
// - SETUP: hold for SETUP_CYC cycles, then SCLK 0->1 and enter HIGH (beat 0).
// - HIGH: hold CLK_DIV cycles, then SCLK 1->0.
//   If beats remain: go to LOW when wdata_valid, else WAIT.
//   If no beats remain: go to HOLD.
// - Loading a data byte: in the cycle wdata is loaded into MOSI, wdata_ready=1.
//   The load happens on the SCLK fall edge, or on WAIT exit.
// - WAIT: SCLK stays 0 and MOSI holds its previous byte.
//   Exit to LOW (with load) in the cycle after wdata_valid is seen. No stall timeout.
// - LOW: hold CLK_DIV cycles, then SCLK 0->1 and enter HIGH (next beat).
// - MISO capture: on every SCLK 0->1 edge of a data beat (not beat 0), rdata<=MISO and rdata_valid=1 for one cycle.
//   MISO during beat 0 is ignored.
// - HOLD: SETUP_CYC cycles with SCLK=0, then SS=1 and enter GAP.
// - GAP: IDLE_CYC cycles with start_ready=0, then IDLE; busy drops on entry to IDLE.
// - Unstalled SS-low time = 2*SETUP_CYC + (2*len+1)*CLK_DIV cycles.
//   SCLK pulse count = len+1 exactly.
// - start_valid outside IDLE is ignored, not queued.
//   cmd, len and wdata changing mid-transaction have no effect except via the wdata handshake.
// - len=0: no wdata_ready and no rdata_valid; exactly one SCLK pulse.
// TESTING
// 1 Reset: sys_reset=1 for 3 cycles -> SS=1, SCLK=0, MOSI=0, busy=0, start_ready=1; no pulses on wdata_ready/rdata_valid.
// 2 cmd=8'hC0, len=0 -> MOSI=C0, one SCLK pulse 4 cycles wide, SS low 8 cycles, no rdata_valid, then start_ready after 2 GAP cycles.
// 3 cmd=8'h80, len=2, wdata 8'h11,8'h22 always valid; MISO model A5 then 5A -> MOSI 80,11,22; 2 wdata_ready pulses;
//   rdata_valid twice with A5, 5A; SS low 24 cycles.
// 4 As 3 but wdata_valid low for 10 cycles before beat 1 -> SCLK low 10 extra cycles, MOSI stays 80, still 3 SCLK pulses.
// 5 sys_reset pulsed during beat-1 HIGH -> next edge SS=1, SCLK=0, busy=0; no further rdata_valid; new cmd 8'h40 len 0 completes normally.
// 6 start_valid held high continuously across two transactions -> second accepted only after IDLE_CYC SS-high cycles; no overlap of SS low.

Source files
------------

// File: rtl/mps_spi_master.sv
// mps_spi_master: byte-parallel SPI initiator, one command beat then len data beats, SCLK divided from clk1
module mps_spi_master #(
  parameter int CLK_DIV   = 4,
  parameter int SETUP_CYC = 2,
  parameter int IDLE_CYC  = 2,
  parameter int LEN_W     = 4
) (
  input  logic             clk1,
  input  logic             sys_reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [7:0]       cmd,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic             busy,
  output logic             SS,
  output logic             SCLK,
  output logic [7:0]       MOSI,
  input  logic [7:0]       MISO
);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, WAIT, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic ss_n, sclk_n, rv_n, wr_n, busy_n, sr_n;
  logic [7:0] mosi_n, rdata_n;
  always_ff @(posedge clk1) begin
    if (sys_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      SS          <= 1'b1;
      SCLK        <= 1'b0;
      MOSI        <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      wdata_ready <= 1'b0;
      busy        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rem         <= rem_n;
      SS          <= ss_n;
      SCLK        <= sclk_n;
      MOSI        <= mosi_n;
      rdata       <= rdata_n;
      rdata_valid <= rv_n;
      wdata_ready <= wr_n;
      busy        <= busy_n;
      start_ready <= sr_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    rem_n   = rem;
    ss_n    = SS;
    sclk_n  = SCLK;
    mosi_n  = MOSI;
    rdata_n = rdata;
    rv_n    = 1'b0;
    wr_n    = 1'b0;
    busy_n  = busy;
    sr_n    = start_ready;
    case (state)
      IDLE: if (start_valid) begin
        state_n = SETUP;
        cnt_n   = '0;
        rem_n   = len;
        ss_n    = 1'b0;
        mosi_n  = cmd;
        busy_n  = 1'b1;
        sr_n    = 1'b0;
      end
      SETUP: if (cnt == 16'(SETUP_CYC - 1)) begin
        state_n = HIGH;
        cnt_n   = '0;
        sclk_n  = 1'b1;
      end
      HIGH: if (cnt == 16'(CLK_DIV - 1)) begin
        cnt_n   = '0;
        sclk_n  = 1'b0;
        state_n = (rem == '0) ? HOLD : (wdata_valid ? LOW : WAIT);
        if (rem != '0 && wdata_valid) begin
          mosi_n = wdata;
          wr_n   = 1'b1;
          rem_n  = rem - LEN_W'(1);
        end
      end
      WAIT: if (wdata_valid) begin
        state_n = LOW;
        cnt_n   = '0;
        mosi_n  = wdata;
        wr_n    = 1'b1;
        rem_n   = rem - LEN_W'(1);
      end
      LOW: if (cnt == 16'(CLK_DIV - 1)) begin
        state_n = HIGH;
        cnt_n   = '0;
        sclk_n  = 1'b1;
        rdata_n = MISO;
        rv_n    = 1'b1;
      end
      HOLD: if (cnt == 16'(SETUP_CYC - 1)) begin
        state_n = GAP;
        cnt_n   = '0;
        ss_n    = 1'b1;
      end
      GAP: if (cnt == 16'(IDLE_CYC - 1)) begin
        state_n = IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
        sr_n    = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mps_spi_master.sv
// tb_mps_spi_master: randomized transactions checked against a cycle-timeline model of the SPI master
module tb_mps_spi_master;
  localparam int D = 4, S = 2, I = 2, LW = 4;
  logic clk1 = 1'b0, sys_reset = 1'b1, start_valid = 1'b0, wdata_valid = 1'b0;
  logic [7:0] cmd = '0, wdata = '0, MISO = '0;
  logic [LW-1:0] len = '0;
  logic start_ready, wdata_ready, rdata_valid, busy, SS, SCLK;
  logic [7:0] rdata, MOSI;
  int n_cmp = 0, n_bad = 0;
  int d[16];
  logic [7:0] wb[16], ms[16];
  always #5 clk1 = ~clk1;
  mps_spi_master #(.CLK_DIV(D), .SETUP_CYC(S), .IDLE_CYC(I), .LEN_W(LW)) dut (
    .clk1(clk1), .sys_reset(sys_reset), .start_valid(start_valid), .start_ready(start_ready),
    .cmd(cmd), .len(len), .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .SS(SS), .SCLK(SCLK),
    .MOSI(MOSI), .MISO(MISO)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk1);
    #1;
  endtask
  task automatic fill(input int dmax);
    for (int i = 0; i < 16; i++) begin
      d[i]  = $urandom_range(dmax, 1);
      wb[i] = 8'($urandom);
      ms[i] = 8'($urandom);
    end
  endtask
  task automatic run_txn(input logic [7:0] c, input int n, input bit keep, input bit abort);
    int e, w, idx, nxt, rises, falls, wrs, rvs, ssl, gap, fl, quiet;
    int L[16], rise[16];
    logic sclk_p;
    logic [7:0] mosi_p;
    rise[0] = S;
    fl = S + D;
    L[0] = 0;
    for (int i = 1; i <= n; i++) begin
      L[i] = (L[i-1] + d[i] > fl) ? L[i-1] + d[i] : fl;
      rise[i] = L[i] + D;
      fl = L[i] + 2 * D;
    end
    cmd = c;
    len = LW'(n);
    start_valid = 1'b1;
    wdata_valid = 1'b0;
    MISO = ms[0];
    w = 0;
    do begin tick(); w++; end while (!busy && w < 50);
    check("accept_lat", w, 1);
    if (!busy) return;
    cmd = 8'($urandom);
    len = LW'($urandom);
    start_valid = keep;
    check("mosi_cmd", MOSI, c);
    check("ss_fall", SS, 0);
    e = 0; idx = 1; nxt = d[1];
    rises = 0; falls = 0; wrs = 0; rvs = 0; ssl = 0;
    sclk_p = SCLK;
    mosi_p = MOSI;
    while (e < 3000) begin
      if (SS) break;
      ssl++;
      if (SCLK && !sclk_p) begin
        if (rises <= n) begin
          check("rise_edge", e, rise[rises]);
          check("mosi_at_rise", MOSI, (rises == 0) ? c : wb[rises]);
        end else check("rise_over", rises, n);
        rises++;
        MISO = (rises < 16) ? ms[rises] : 8'h00;
      end
      if (!SCLK && sclk_p) begin
        if (falls <= n) check("fall_edge", e, rise[falls] + D);
        falls++;
      end
      if (MOSI !== mosi_p) check("mosi_while_low", SCLK, 0);
      if (wdata_ready) begin
        wrs++;
        if (wrs <= n) begin
          check("load_edge", e, L[wrs]);
          check("mosi_load", MOSI, wb[wrs]);
        end else check("wready_over", wrs, n);
        idx++;
        nxt = e + ((idx <= n) ? d[idx] : 0);
      end
      if (rdata_valid) begin
        rvs++;
        if (rvs <= n) begin
          check("rv_edge", e, rise[rvs]);
          check("rdata", rdata, ms[rvs]);
        end else check("rvalid_over", rvs, n);
        if (abort && rvs == 1) begin
          sys_reset = 1'b1;
          wdata_valid = 1'b0;
          tick();
          check("rst_ss", SS, 1);
          check("rst_sclk", SCLK, 0);
          check("rst_busy", busy, 0);
          check("rst_ready", start_ready, 1);
          check("rst_mosi", MOSI, 0);
          check("rst_rdata", rdata, 0);
          sys_reset = 1'b0;
          quiet = 0;
          for (int k = 0; k < 20; k++) begin
            tick();
            if (rdata_valid || wdata_ready || SCLK || !SS) quiet++;
          end
          check("post_rst_quiet", quiet, 0);
          return;
        end
      end
      sclk_p = SCLK;
      mosi_p = MOSI;
      wdata_valid = (idx <= n) && (e + 1 >= nxt);
      wdata = wdata_valid ? wb[idx] : 8'($urandom);
      tick();
      e++;
    end
    wdata_valid = 1'b0;
    check("ss_low", ssl, fl + S);
    check("sclk_pulses", rises, n + 1);
    check("sclk_falls", falls, n + 1);
    check("wready_cnt", wrs, n);
    check("rvalid_cnt", rvs, n);
    gap = 0;
    while (!start_ready && gap < 50) begin
      check("ss_in_gap", SS, 1);
      tick();
      gap++;
    end
    check("gap", gap, I);
    check("idle_busy", busy, 0);
  endtask
  initial begin
    sys_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_ss", SS, 1);
      check("reset_sclk", SCLK, 0);
      check("reset_mosi", MOSI, 0);
      check("reset_busy", busy, 0);
      check("reset_ready", start_ready, 1);
      check("reset_pulses", {wdata_ready, rdata_valid}, 0);
    end
    sys_reset = 1'b0;
    tick();
    fill(1);
    run_txn(8'hC0, 0, 1'b0, 1'b0);
    fill(1);
    wb[1] = 8'h11; wb[2] = 8'h22; ms[1] = 8'hA5; ms[2] = 8'h5A;
    run_txn(8'h80, 2, 1'b0, 1'b0);
    d[1] = 16;
    run_txn(8'h80, 2, 1'b0, 1'b0);
    fill(3);
    run_txn(8'h80, 2, 1'b0, 1'b1);
    run_txn(8'h40, 0, 1'b0, 1'b0);
    fill(2);
    run_txn(8'h33, 3, 1'b1, 1'b0);
    fill(2);
    run_txn(8'h44, 1, 1'b0, 1'b0);
    fill(1);
    run_txn(8'hEE, 15, 1'b0, 1'b0);
    for (int t = 0; t < 20; t++) begin
      fill(8);
      run_txn(8'($urandom), $urandom_range(15, 0), 1'($urandom), 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
